// File: rtl/startup_sequencer_pkg.sv
// Shared types and limits for the post-reset startup sequencer.
// No logic; elaboration checks in the modules reference these limits.
package startup_sequencer_pkg;
  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } seq_state_t;

  localparam int STAGE_DELAY_MIN = 1;
  localparam int NUM_STAGES_MIN  = 1;
endpackage

// File: rtl/startup_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the block gating subsystem enables (slave).
// restart/hold flow into the sequencer; staged enables and status flow out, no handshake.
interface startup_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  restart;
  logic                  hold;
  logic                  first;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  busy;
  logic                  ready;

  modport master (input restart, hold, output first, stage_en, busy, ready);
  modport slave  (output restart, hold, input first, stage_en, busy, ready);
endinterface

// File: rtl/startup_sequencer_stage_timer.sv
// Stage spacing counter: tc pulses combinationally on the enabled cycle that completes STAGE_DELAY counts.
// Frozen while en is low; clr (or its own terminal count) returns it to zero on the next edge.
module startup_sequencer_stage_timer
  import startup_sequencer_pkg::*;
#(
  parameter int STAGE_DELAY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int CNT_W = $clog2(STAGE_DELAY + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(STAGE_DELAY - 1);

  if (STAGE_DELAY < STAGE_DELAY_MIN) begin : g_bad_delay
    $error("STAGE_DELAY below minimum");
  end

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == TC_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/startup_sequencer.sv
// Post-reset sequencer: releases NUM_STAGES thermometer enables STAGE_DELAY clocks apart, then ready.
// All outputs registered; hold stretches the sequence one cycle per held edge, restart reruns it.
module startup_sequencer
  import startup_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 4
) (
  input logic                 clk,
  input logic                 rst,
  startup_sequencer_if.master bus
);
  localparam int SW = $clog2(NUM_STAGES + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  if (NUM_STAGES < NUM_STAGES_MIN) begin : g_bad_stages
    $error("NUM_STAGES below minimum");
  end

  seq_state_t            state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
  logic                  first_q, first_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  tc;

  startup_sequencer_stage_timer #(
    .STAGE_DELAY (STAGE_DELAY)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  ((state_q == RUN) && !bus.hold),
    .clr (bus.restart),
    .tc  (tc)
  );

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    stage_en_d = stage_en_q;
    first_d    = 1'b0;
    busy_d     = busy_q;
    ready_d    = ready_q;
    // restart outranks any stage release or completion landing on the same edge
    if (bus.restart) begin
      state_d    = RUN;
      stage_d    = '0;
      stage_en_d = '0;
      first_d    = 1'b1;
      busy_d     = 1'b1;
      ready_d    = 1'b0;
    end else if ((state_q == RUN) && tc) begin
      stage_en_d = stage_en_q | (NUM_STAGES'(1) << stage_q);
      stage_d    = stage_q + 1'b1;
      if (stage_q == LAST_STAGE) begin
        state_d = DONE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      stage_q    <= '0;
      stage_en_q <= '0;
      first_q    <= 1'b1;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      stage_en_q <= stage_en_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.first    = first_q;
  assign bus.stage_en = stage_en_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
endmodule
